// File: rtl/llc_fetch.sv
// Low-level command fetcher: reads a type byte and, unless it is the end-of-list
// marker, a count byte from byte-wide command RAM. Optional LLC_ZERO_CNT_CLAMP_EN.
module llc_fetch #(
  parameter int          ADDR_W      = 16,
  parameter int          MEM_LATENCY = 1,
  parameter logic [7:0]  EOL_TYPE    = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [7:0]        llct,
  output logic [7:0]        llcc,
  output logic              eol,
  output logic              busy,
  output logic              done,
`ifdef LLC_ZERO_CNT_CLAMP_EN
  output logic              clamped,
`endif
  output logic [ADDR_W-1:0] next_addr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_T   = 3'd1;
  localparam logic [2:0] S_WAIT_T = 3'd2;
  localparam logic [2:0] S_RD_C   = 3'd3;
  localparam logic [2:0] S_WAIT_C = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [2:0]        LAT  = 3'(MEM_LATENCY);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO  = ADDR_W'(2);

  logic [2:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [7:0]        llct_q, llct_d;
  logic [7:0]        llcc_q, llcc_d;
  logic              eol_q, eol_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              clamped_q, clamped_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    llct_d      = llct_q;
    llcc_d      = llcc_q;
    eol_d       = eol_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    next_addr_d = next_addr_q;
    clamped_d   = clamped_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          mem_addr_d = base_addr;
          mem_rd_d   = 1'b1;
          busy_d     = 1'b1;
          clamped_d  = 1'b0;
          state_d    = S_RD_T;
        end
      end
      S_RD_T: begin
        cnt_d   = LAT;
        state_d = S_WAIT_T;
      end
      S_WAIT_T: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          llct_d = mem_data;
          if (mem_data == EOL_TYPE) begin
            // End of list: no count byte is fetched.
            llcc_d      = 8'h00;
            eol_d       = 1'b1;
            next_addr_d = base_q + ONE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_DONE;
          end else begin
            mem_addr_d = base_q + ONE;
            mem_rd_d   = 1'b1;
            state_d    = S_RD_C;
          end
        end
      end
      S_RD_C: begin
        cnt_d   = LAT;
        state_d = S_WAIT_C;
      end
      S_WAIT_C: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          llcc_d = mem_data;
`ifdef LLC_ZERO_CNT_CLAMP_EN
          // A zero count would make the downstream timer expire immediately.
          if (mem_data == 8'h00) begin
            llcc_d    = 8'h01;
            clamped_d = 1'b1;
          end
`endif
          eol_d       = 1'b0;
          next_addr_d = base_q + TWO;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      base_q      <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      llct_q      <= 8'h00;
      llcc_q      <= 8'h00;
      eol_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      next_addr_q <= '0;
      clamped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      llct_q      <= llct_d;
      llcc_q      <= llcc_d;
      eol_q       <= eol_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      next_addr_q <= next_addr_d;
      clamped_q   <= clamped_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign llct      = llct_q;
  assign llcc      = llcc_q;
  assign eol       = eol_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign next_addr = next_addr_q;
`ifdef LLC_ZERO_CNT_CLAMP_EN
  assign clamped   = clamped_q;
`else
  logic unused_clamped;
  assign unused_clamped = clamped_q;
`endif

endmodule

// File: tb/tb_llc_fetch.sv
// Scoreboard bench for llc_fetch: dut0 with MEM_LATENCY=1, dut1 with MEM_LATENCY=3.
module tb_llc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start0, start1;
  logic [15:0] base0, base1;
  logic [15:0] mem_addr0, mem_addr1, next0, next1;
  logic        mem_rd0, mem_rd1, eol0, eol1, busy0, busy1, done0, done1;
  logic [7:0]  mem_data0, mem_data1, llct0, llct1, llcc0, llcc1;
`ifdef LLC_ZERO_CNT_CLAMP_EN
  logic        clamped0, clamped1;
`endif

  llc_fetch #(.ADDR_W(16), .MEM_LATENCY(1), .EOL_TYPE(8'hFF)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .base_addr(base0),
    .mem_addr(mem_addr0), .mem_rd(mem_rd0), .mem_data(mem_data0),
    .llct(llct0), .llcc(llcc0), .eol(eol0), .busy(busy0), .done(done0),
`ifdef LLC_ZERO_CNT_CLAMP_EN
    .clamped(clamped0),
`endif
    .next_addr(next0));

  llc_fetch #(.ADDR_W(16), .MEM_LATENCY(3), .EOL_TYPE(8'hFF)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .base_addr(base1),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_data(mem_data1),
    .llct(llct1), .llcc(llcc1), .eol(eol1), .busy(busy1), .done(done1),
`ifdef LLC_ZERO_CNT_CLAMP_EN
    .clamped(clamped1),
`endif
    .next_addr(next1));

  // RAM models: data is valid only in the exact latency cycle, garbage otherwise.
  logic [7:0] ram0 [0:65535];
  logic [7:0] ram1 [0:65535];
  logic [7:0] p1 [0:2];
  always @(posedge clk) mem_data0 <= mem_rd0 ? ram0[mem_addr0] : 8'hEE;
  always @(posedge clk) begin
    p1[0] <= mem_rd1 ? ram1[mem_addr1] : 8'hEE;
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign mem_data1 = p1[2];

  typedef struct {
    logic [7:0]  t;
    logic [7:0]  c;
    logic        e;
    logic [15:0] na;
    logic        clmp;
    int          at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [7:0] t, input logic [7:0] c, input logic e,
                              input logic [15:0] na, input logic clmp, input int at);
    exp_t x;
    x.t = t; x.c = c; x.e = e; x.na = na; x.clmp = clmp; x.at = at;
    return x;
  endfunction

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0_unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("d0_done_cycle", cyc, e.at);
        chk("d0_llct", {24'h0, llct0}, {24'h0, e.t});
        chk("d0_llcc", {24'h0, llcc0}, {24'h0, e.c});
        chk("d0_eol", {31'h0, eol0}, {31'h0, e.e});
        chk("d0_next_addr", {16'h0, next0}, {16'h0, e.na});
        chk("d0_busy_at_done", {31'h0, busy0}, 32'h0);
`ifdef LLC_ZERO_CNT_CLAMP_EN
        chk("d0_clamped", {31'h0, clamped0}, {31'h0, e.clmp});
`endif
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("d1_done_cycle", cyc, e.at);
        chk("d1_llct", {24'h0, llct1}, {24'h0, e.t});
        chk("d1_llcc", {24'h0, llcc1}, {24'h0, e.c});
        chk("d1_eol", {31'h0, eol1}, {31'h0, e.e});
        chk("d1_next_addr", {16'h0, next1}, {16'h0, e.na});
`ifdef LLC_ZERO_CNT_CLAMP_EN
        chk("d1_clamped", {31'h0, clamped1}, {31'h0, e.clmp});
`endif
      end
    end
  end

  initial begin
    int c0;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; base0 = '0; base1 = '0;
    ram0[16'h0010] = 8'h20; ram0[16'h0011] = 8'h05;
    ram0[16'h0020] = 8'hFF;
    ram0[16'hFFFF] = 8'h11; ram0[16'h0000] = 8'h09;
    ram1[16'h0040] = 8'h33; ram1[16'h0041] = 8'h00;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_mem_rd", {31'h0, mem_rd0}, 32'h0);
    chk("rst_mem_addr", {16'h0, mem_addr0}, 32'h0);
    chk("rst_llct", {24'h0, llct0}, 32'h0);
    chk("rst_llcc", {24'h0, llcc0}, 32'h0);
    chk("rst_eol", {31'h0, eol0}, 32'h0);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_done", {31'h0, done0}, 32'h0);
    chk("rst_next_addr", {16'h0, next0}, 32'h0);
    chk("rst_d1_busy", {31'h0, busy1}, 32'h0);
    tick();

    // Test 1: normal fetch, latency 1
    start0 = 1'b1; base0 = 16'h0010; c0 = cyc;
    q0.push_back(mk(8'h20, 8'h05, 1'b0, 16'h0012, 1'b0, c0 + 5));
    tick(); start0 = 1'b0;
    chk("t1_c1_mem_rd", {31'h0, mem_rd0}, 32'h1);
    chk("t1_c1_addr", {16'h0, mem_addr0}, 32'h0010);
    chk("t1_c1_busy", {31'h0, busy0}, 32'h1);
    tick();
    chk("t1_c2_mem_rd", {31'h0, mem_rd0}, 32'h0);
    chk("t1_c2_addr_hold", {16'h0, mem_addr0}, 32'h0010);
    chk("t1_c2_busy", {31'h0, busy0}, 32'h1);
    tick();
    chk("t1_c3_mem_rd", {31'h0, mem_rd0}, 32'h1);
    chk("t1_c3_addr", {16'h0, mem_addr0}, 32'h0011);
    chk("t1_c3_llct_early", {24'h0, llct0}, 32'h20);
    tick();
    chk("t1_c4_mem_rd", {31'h0, mem_rd0}, 32'h0);
    chk("t1_c4_busy", {31'h0, busy0}, 32'h1);
    tick();
    chk("t1_c5_done", {31'h0, done0}, 32'h1);
    tick(); tick();
    chk("t1_hold_llcc", {24'h0, llcc0}, 32'h05);
    chk("t1_done_pulse", {31'h0, done0}, 32'h0);

    // Test 2: end-of-list marker
    start0 = 1'b1; base0 = 16'h0020; c0 = cyc;
    q0.push_back(mk(8'hFF, 8'h00, 1'b1, 16'h0021, 1'b0, c0 + 3));
    tick(); start0 = 1'b0;
    chk("t2_c1_mem_rd", {31'h0, mem_rd0}, 32'h1);
    tick();
    chk("t2_c2_mem_rd", {31'h0, mem_rd0}, 32'h0);
    tick();
    chk("t2_c3_mem_rd", {31'h0, mem_rd0}, 32'h0);
    chk("t2_c3_addr", {16'h0, mem_addr0}, 32'h0020);
    tick(); tick();

    // Test 3: starts while busy / in DONE ignored; start right after done accepted
    start0 = 1'b1; base0 = 16'h0010; c0 = cyc;
    q0.push_back(mk(8'h20, 8'h05, 1'b0, 16'h0012, 1'b0, c0 + 5));
    tick(); start0 = 1'b0;
    tick(); start0 = 1'b1; base0 = 16'h0020;
    tick(); start0 = 1'b0;
    tick(); start0 = 1'b1;
    tick(); base0 = 16'h0010;
    chk("t3_c5_done", {31'h0, done0}, 32'h1);
    tick();
    q0.push_back(mk(8'h20, 8'h05, 1'b0, 16'h0012, 1'b0, c0 + 11));
    tick(); start0 = 1'b0;
    chk("t3_c7_mem_rd", {31'h0, mem_rd0}, 32'h1);
    repeat (6) tick();

    // Test 4: address wrap
    start0 = 1'b1; base0 = 16'hFFFF; c0 = cyc;
    q0.push_back(mk(8'h11, 8'h09, 1'b0, 16'h0001, 1'b0, c0 + 5));
    tick(); start0 = 1'b0;
    tick(); tick();
    chk("t4_c3_addr_wrap", {16'h0, mem_addr0}, 32'h0000);
    chk("t4_c3_mem_rd", {31'h0, mem_rd0}, 32'h1);
    repeat (4) tick();

    // Test 5: reset mid-fetch
    start0 = 1'b1; base0 = 16'h0010; c0 = cyc;
    tick(); start0 = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("t5_mem_rd", {31'h0, mem_rd0}, 32'h0);
    chk("t5_busy", {31'h0, busy0}, 32'h0);
    chk("t5_llct", {24'h0, llct0}, 32'h0);
    chk("t5_llcc", {24'h0, llcc0}, 32'h0);
    chk("t5_next_addr", {16'h0, next0}, 32'h0);
    repeat (4) tick();
    chk("t5_no_done", {31'h0, done0}, 32'h0);
    start0 = 1'b1; base0 = 16'h0010; c0 = cyc;
    q0.push_back(mk(8'h20, 8'h05, 1'b0, 16'h0012, 1'b0, c0 + 5));
    tick(); start0 = 1'b0;
    repeat (6) tick();

    // Test 6: latency 3, zero count byte
    start1 = 1'b1; base1 = 16'h0040; c0 = cyc;
`ifdef LLC_ZERO_CNT_CLAMP_EN
    q1.push_back(mk(8'h33, 8'h01, 1'b0, 16'h0042, 1'b1, c0 + 9));
`else
    q1.push_back(mk(8'h33, 8'h00, 1'b0, 16'h0042, 1'b0, c0 + 9));
`endif
    tick(); start1 = 1'b0;
    chk("t6_c1_mem_rd", {31'h0, mem_rd1}, 32'h1);
    repeat (4) tick();
    chk("t6_c5_mem_rd", {31'h0, mem_rd1}, 32'h1);
    chk("t6_c5_addr", {16'h0, mem_addr1}, 32'h0041);
    repeat (8) tick();

    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
